// File: rtl/cordic_iter.sv
// cordic_iter: iterative fixed-point CORDIC engine (rotation and vectoring).
// One micro-rotation per clock, single issue, start/ready/done handshake.
// Optional quadrant pre-rotation for full +/-pi coverage: define CORDIC_QUADRANT_EN.
module cordic_iter #(
    parameter int INT_W      = 4,
    parameter int FRAC_W     = 20,
    parameter int DATA_W     = INT_W + FRAC_W,
    parameter int ITERATIONS = 16,
    parameter int CNT_W      = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] y_in,
    input  logic signed [DATA_W-1:0] z_in,
    output logic                     ready,
    output logic                     done,
    output logic signed [DATA_W-1:0] x_out,
    output logic signed [DATA_W-1:0] y_out,
    output logic signed [DATA_W-1:0] z_out
);

    // CORDIC gain compensation 0.607252935, scaled to FRAC_W
    localparam logic signed [DATA_W-1:0] K_INIT =
        DATA_W'($rtoi(0.607252935 * (2.0 ** FRAC_W) + 0.5));

`ifdef CORDIC_QUADRANT_EN
    localparam logic signed [DATA_W-1:0] HALF_PI =
        DATA_W'($rtoi(1.5707963267948966 * (2.0 ** FRAC_W) + 0.5));
`endif

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        ITER,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic                     mode_q;
    logic signed [DATA_W-1:0] x_q, y_q, z_q;
    logic        [CNT_W-1:0]  cnt_q;

    logic signed [DATA_W-1:0] atan_tab [ITERATIONS];
    logic signed [DATA_W-1:0] atan_i;
    logic signed [DATA_W-1:0] x_b, y_b;
    logic signed [DATA_W-1:0] x_pre, y_pre, z_pre;
    logic signed [DATA_W-1:0] x_sh, y_sh;
    logic signed [DATA_W-1:0] x_nx, y_nx, z_nx;
    logic                     d_pos;

    // Elaboration-time arctangent table: round(atan(2^-i) * 2^FRAC_W)
    for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
        localparam real ATAN_R = $atan(1.0 / (2.0 ** g)) * (2.0 ** FRAC_W);
        assign atan_tab[g] = DATA_W'($rtoi(ATAN_R + 0.5));
    end

    assign ready = (state_q == IDLE);

    // Select the table entry for the current iteration index
    always_comb begin
        atan_i = '0;
        for (int unsigned k = 0; k < ITERATIONS; k++) begin
            if (cnt_q == CNT_W'(k)) atan_i = atan_tab[k];
        end
    end

    // Initial vector for the iteration loop, with optional quadrant fold
    always_comb begin
        x_b   = mode_q ? x_q : K_INIT;
        y_b   = mode_q ? y_q : '0;
        x_pre = x_b;
        y_pre = y_b;
        z_pre = z_q;
`ifdef CORDIC_QUADRANT_EN
        if (!mode_q) begin
            if (z_q > HALF_PI) begin
                x_pre = -y_b;
                y_pre = x_b;
                z_pre = z_q - HALF_PI;
            end else if (z_q < -HALF_PI) begin
                x_pre = y_b;
                y_pre = -x_b;
                z_pre = z_q + HALF_PI;
            end
        end else if (x_b[DATA_W-1]) begin
            if (!y_b[DATA_W-1]) begin
                x_pre = y_b;
                y_pre = -x_b;
                z_pre = z_q + HALF_PI;
            end else begin
                x_pre = -y_b;
                y_pre = x_b;
                z_pre = z_q - HALF_PI;
            end
        end
`endif
    end

    // One micro-rotation: direction from sign of z (rotation) or y (vectoring)
    always_comb begin
        d_pos = mode_q ? y_q[DATA_W-1] : ~z_q[DATA_W-1];
        x_sh  = x_q >>> cnt_q;
        y_sh  = y_q >>> cnt_q;
        if (d_pos) begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - atan_i;
        end else begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + atan_i;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PRE;
            PRE:     state_d = ITER;
            ITER:    if (cnt_q == CNT_W'(ITERATIONS - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Datapath: capture, pre-load, iterate, then register results.
    // Results are loaded at the end of DONE, so the done pulse coincides with
    // the first IDLE cycle; a start held high is accepted in that same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            cnt_q  <= '0;
            done   <= 1'b0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        x_q    <= x_in;
                        y_q    <= y_in;
                        z_q    <= z_in;
                    end
                end
                PRE: begin
                    x_q   <= x_pre;
                    y_q   <= y_pre;
                    z_q   <= z_pre;
                    cnt_q <= '0;
                end
                ITER: begin
                    x_q   <= x_nx;
                    y_q   <= y_nx;
                    z_q   <= z_nx;
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    x_out <= x_q;
                    y_out <= y_q;
                    z_out <= z_q;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: directed-vector bench for cordic_iter with a bit-true
// arithmetic CORDIC model and literal sin/cos/atan/magnitude expectations.
module tb_cordic_iter;

    localparam int INT_W  = 4;
    localparam int FRAC_W = 20;
    localparam int DATA_W = INT_W + FRAC_W;
    localparam int ITER   = 16;
    localparam int K_LIT  = 'h09B74F;
    localparam int HPI    = 1647099;

    typedef struct {
        bit m;
        int x, y, z;
        bit lit;
        int lx, ly, lz;
        int tx, ty, tz;
    } op_t;

    logic clk = 1'b0;
    logic rst, start, mode;
    logic signed [DATA_W-1:0] x_in, y_in, z_in;
    logic ready, done;
    logic signed [DATA_W-1:0] x_out, y_out, z_out;

    int  errors = 0;
    int  checks = 0;
    int  fail_prints = 0;
    bit  stop_req = 1'b0;
    op_t ops[$];

    always #5 clk = ~clk;

    cordic_iter #(
        .INT_W(INT_W), .FRAC_W(FRAC_W), .DATA_W(DATA_W),
        .ITERATIONS(ITER), .CNT_W(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .ready(ready), .done(done),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    function automatic int wrap(input longint v);
        logic signed [DATA_W-1:0] t;
        t = v[DATA_W-1:0];
        return int'(t);
    endfunction

    // Reference CORDIC written directly from the algorithm in integer math
    function automatic void cordic_model(input bit m, input int xi, input int yi,
                                         input int zi, output int xo, output int yo,
                                         output int zo);
        int x, y, z, t, xs, ys, at;
        bit pos;
        x = m ? xi : K_LIT;
        y = m ? yi : 0;
        z = zi;
`ifdef CORDIC_QUADRANT_EN
        if (!m) begin
            if (z > HPI)       begin t = x; x = wrap(-y); y = t; z = wrap(z - HPI); end
            else if (z < -HPI) begin t = x; x = y; y = wrap(-t); z = wrap(z + HPI); end
        end else if (x < 0) begin
            if (y >= 0) begin t = x; x = y; y = wrap(-t); z = wrap(z + HPI); end
            else        begin t = x; x = wrap(-y); y = t; z = wrap(z - HPI); end
        end
`endif
        for (int i = 0; i < ITER; i++) begin
            at  = int'($atan(1.0 / (2.0 ** i)) * (2.0 ** FRAC_W));
            xs  = x >>> i;
            ys  = y >>> i;
            pos = m ? (y < 0) : (z >= 0);
            if (pos) begin x = wrap(x - ys); y = wrap(y + xs); z = wrap(z - at); end
            else     begin x = wrap(x + ys); y = wrap(y - xs); z = wrap(z + at); end
        end
        xo = x; yo = y; zo = z;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
            end
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp, input int tol);
        int diff;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        checks++;
        if (diff > tol) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got %0d, expected %0d +/-%0d", name, act, exp, tol);
            end
        end
    endtask

    // Compare process: per-cycle handshake and output check against the model
    initial begin : compare
        int  k, issue_k, pend_op, op_n;
        bit  pend, exp_done, exp_ready, lat_done;
        int  ex, ey, ez, px, py, pz;
        k = 0; issue_k = 0; pend_op = 0; op_n = 0;
        pend = 1'b0; lat_done = 1'b0;
        ex = 0; ey = 0; ez = 0; px = 0; py = 0; pz = 0;
        while (!stop_req) begin
            @(negedge clk);
            k++;
            if (!rst) begin
                pend = 1'b0;
                ex = 0; ey = 0; ez = 0;
                chk("rst_ready", int'(ready), 1);
                chk("rst_done", int'(done), 0);
                chk("rst_x_out", int'(x_out), 0);
                chk("rst_y_out", int'(y_out), 0);
                chk("rst_z_out", int'(z_out), 0);
                continue;
            end
            exp_done  = pend && (k == issue_k + ITER + 3);
            exp_ready = !(pend && (k > issue_k) && (k <= issue_k + ITER + 2));
            if (done && pend && !lat_done) begin
                lat_done = 1'b1;
                chk("latency_cycles", k - (issue_k + 1), 18);
            end
            chk("done", int'(done), int'(exp_done));
            chk("ready", int'(ready), int'(exp_ready));
            if (exp_done) begin
                ex = px; ey = py; ez = pz;
                pend = 1'b0;
                if (pend_op < ops.size() && ops[pend_op].lit) begin
                    chk_tol($sformatf("lit%0d_x", pend_op), int'(x_out), ops[pend_op].lx, ops[pend_op].tx);
                    chk_tol($sformatf("lit%0d_y", pend_op), int'(y_out), ops[pend_op].ly, ops[pend_op].ty);
                    chk_tol($sformatf("lit%0d_z", pend_op), int'(z_out), ops[pend_op].lz, ops[pend_op].tz);
                end
            end
            chk("x_out", int'(x_out), ex);
            chk("y_out", int'(y_out), ey);
            chk("z_out", int'(z_out), ez);
            if (start && exp_ready) begin
                cordic_model(mode, int'(x_in), int'(y_in), int'(z_in), px, py, pz);
                issue_k = k;
                pend    = 1'b1;
                pend_op = op_n;
                op_n++;
            end
        end
        chk("no_pending_done", int'(pend), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic wait_ready();
        for (int c = 0; c < 100 && !ready; c++) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done();
        for (int c = 0; c < 100 && !done; c++) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input bit m, input int x, input int y, input int z);
        mode = m;
        x_in = DATA_W'(x);
        y_in = DATA_W'(y);
        z_in = DATA_W'(z);
    endtask

    task automatic run_op(input op_t o);
        wait_ready();
        drive(o.m, o.x, o.y, o.z);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
    endtask

    // Stimulus
    initial begin : stim
        rst = 1'b0; start = 1'b0;
        drive(1'b0, 0, 0, 0);
        //              m     x         y         z        lit   lx       ly       lz       tx   ty   tz
        ops.push_back('{1'b0, 0,        0,        0,       1'b1, 1048576, 0,       0,       64,  64,  48});
        ops.push_back('{1'b0, 0,        0,        823550,  1'b1, 741455,  741455,  0,       64,  64,  48});
        ops.push_back('{1'b0, 0,        0,        -823550, 1'b1, 741455,  -741455, 0,       64,  64,  48});
        ops.push_back('{1'b0, 0,        0,        1647099, 1'b1, 0,       1048576, 0,       64,  64,  48});
        ops.push_back('{1'b1, 1048576,  1048576,  0,       1'b1, 2442000, 0,       823550,  96,  160, 48});
        ops.push_back('{1'b1, 1048576,  1048576,  100000,  1'b1, 2442000, 0,       923550,  96,  160, 48});
        ops.push_back('{1'b1, 1048576,  -524288,  0,       1'b1, 1930569, 0,       -486170, 96,  160, 48});
        ops.push_back('{1'b1, 1048576,  0,        0,       1'b1, 1726753, 0,       0,       96,  160, 48});
`ifdef CORDIC_QUADRANT_EN
        ops.push_back('{1'b0, 0,        0,        2470649, 1'b1, -741455, 741455,  0,       64,  64,  48});
        ops.push_back('{1'b0, 0,        0,        -2470649,1'b1, -741455, -741455, 0,       64,  64,  48});
        ops.push_back('{1'b1, -1048576, 0,        0,       1'b1, 1726753, 0,       3294199, 96,  160, 48});
        ops.push_back('{1'b1, -1048576, -1048576, 0,       1'b1, 2442000, 0,       -2470649,96,  160, 48});
`endif
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < ops.size(); i++) run_op(ops[i]);
        @(posedge clk); #1;

        // Start pulse during ITER is ignored; start held high re-issues on ready
        drive(1'b0, 0, 0, 300000);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        drive(1'b0, 0, 0, -400000);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        drive(1'b0, 0, 0, 500000);
        start = 1'b1;
        wait_done();
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        @(posedge clk); #1;

        // Asynchronous reset five cycles into an operation aborts it
        drive(1'b1, 1048576, 524288, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (ITER + 6) begin @(posedge clk); #1; end

        // Recovery after reset
        run_op('{1'b0, 0, 0, 600000, 1'b0, 0, 0, 0, 0, 0, 0});
        repeat (4) begin @(posedge clk); #1; end
        stop_req = 1'b1;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
